ov7670_capture: RTL

- Camera-side capture stage that feeds the frame buffer read by the VGA display stage.
- Samples the OV7670 parallel bus (vsync, href, 8-bit data) in RGB444 mode and assembles two bytes per pixel into 12-bit {R,G,B} words.
- Writes each pixel to a linear frame-buffer address, row-major, starting at 0 for every frame.
- The display stage reads the same address space as frame_addr/frame_pixel, 640x480 = 307200 words.

---
 rtl/ov7670_capture_if.sv | 23 ++
 rtl/ov7670_capture.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ov7670_capture_if.sv
// Camera byte bus in, frame-buffer write port out.
// master = capture block, slave = camera model / frame-buffer side.
interface ov7670_capture_if #(
    parameter int ADDR_W = 19
);
    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_data;
    logic [ADDR_W-1:0] frame_addr;
    logic [11:0]       frame_pixel;
    logic              frame_we;
    logic              frame_done;

    modport master (
        input  cam_vsync, cam_href, cam_data,
        output frame_addr, frame_pixel, frame_we, frame_done
    );

    modport slave (
        output cam_vsync, cam_href, cam_data,
        input  frame_addr, frame_pixel, frame_we, frame_done
    );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: pairs camera bytes into 12-bit pixels and writes them
// row-major into the frame buffer, restarting at address 0 on every frame.
//
// state      | meaning
// IDLE       | capture disabled, no writes
// WAIT_FRAME | armed, waiting for vsync falling edge
// ACTIVE     | inside a captured frame, writing pixels
module ov7670_capture #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int ADDR_W   = 19
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               capture_en,
    ov7670_capture_if.master   bus,
    output logic [9:0]         line_count,
    output logic               overflow
);

    localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W+1)'(H_PIXELS * V_LINES);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} state_t;

    state_t            state;
    logic              vsync_q;
    logic              vsync_qq;
    logic              href_q;
    logic              href_qq;
    logic [7:0]        data_q;
    logic              byte_phase;
    logic [3:0]        hi_nib;
    logic [ADDR_W-1:0] pix_addr;

    logic frame_start;
    logic frame_end;
    logic line_end;

    assign frame_start = vsync_qq & ~vsync_q;
    assign frame_end   = ~vsync_qq & vsync_q;
    assign line_end    = href_qq & ~href_q;

    always_ff @(posedge pclk) begin
        if (reset) begin
            state           <= IDLE;
            vsync_q         <= 1'b0;
            vsync_qq        <= 1'b0;
            href_q          <= 1'b0;
            href_qq         <= 1'b0;
            data_q          <= 8'd0;
            byte_phase      <= 1'b0;
            hi_nib          <= 4'd0;
            pix_addr        <= '0;
            line_count      <= 10'd0;
            overflow        <= 1'b0;
            bus.frame_addr  <= '0;
            bus.frame_pixel <= 12'd0;
            bus.frame_we    <= 1'b0;
            bus.frame_done  <= 1'b0;
        end else begin
            vsync_q  <= bus.cam_vsync;
            href_q   <= bus.cam_href;
            data_q   <= bus.cam_data;
            vsync_qq <= vsync_q;
            href_qq  <= href_q;

            bus.frame_we   <= 1'b0;
            bus.frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (capture_en) begin
                        state <= WAIT_FRAME;
                    end
                end

                // Disable wins over a coincident frame start: never arm a frame we were told to skip.
                WAIT_FRAME: begin
                    if (!capture_en) begin
                        state <= IDLE;
                    end else if (frame_start) begin
                        state      <= ACTIVE;
                        pix_addr   <= '0;
                        line_count <= 10'd0;
                        overflow   <= 1'b0;
                        byte_phase <= 1'b0;
                    end
                end

                ACTIVE: begin
                    if (href_q) begin
                        if (!byte_phase) begin
                            hi_nib     <= data_q[3:0];
                            byte_phase <= 1'b1;
                        end else begin
                            byte_phase <= 1'b0;
                            if ({1'b0, pix_addr} < PIX_LIMIT) begin
                                bus.frame_pixel <= {hi_nib, data_q};
                                bus.frame_addr  <= pix_addr;
                                bus.frame_we    <= 1'b1;
                                pix_addr        <= pix_addr + 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end else if (line_end) begin
                        byte_phase <= 1'b0;
                        if (line_count != 10'd1023) begin
                            line_count <= line_count + 10'd1;
                        end
                    end

                    // A pixel completing on this same edge is still written above.
                    if (frame_end) begin
                        bus.frame_done <= 1'b1;
                        state          <= capture_en ? WAIT_FRAME : IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
